// File: rtl/fpu_pkg.sv
// fpu_pkg: shared float types, constants and stage-register layouts for the FPU pipes
package fpu_pkg;
    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
    } float_t;

    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam int          BIAS    = 127;

    typedef struct packed {
        logic        sp;
        logic [31:0] spv;
        logic        s;
        logic [7:0]  e;
        logic        sub;
        logic [26:0] a;
        logic [26:0] b;
    } s1_t;

    typedef struct packed {
        logic        sp;
        logic [31:0] spv;
        logic        s;
        logic [7:0]  e;
        logic [27:0] sum;
        logic [4:0]  lz;
    } s2_t;
endpackage

// File: rtl/fpu_lzc28.sv
// fpu_lzc28: combinational leading-zero count of a 28-bit vector (28 when all zero)
module fpu_lzc28 (
    input  logic [27:0] v,
    output logic [4:0]  lz
);
    always_comb begin
        lz = 5'd28;
        for (int i = 0; i < 28; i++) lz = v[i] ? 5'(27 - i) : lz;
    end
endmodule

// File: rtl/fsub_pipe.sv
// fsub_pipe: 3-stage IEEE-754 single-precision subtractor y = x1 - x2, RNE, flush-to-zero
module fsub_pipe
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf
);
    float_t fa, fb, xa, xb;
    s1_t c1, r1;
    s2_t c2, r2;
    logic v1, v2, adv, swap, a_inf, a_nan, b_inf, b_nan, up, novf;
    logic [31:0] nb, ny;
    logic [7:0] diff;
    logic [4:0] sh, lz;
    logic [26:0] bb;
    logic [27:0] sum, t;
    logic [23:0] fr;
    logic signed [9:0] en;

    assign adv = !out_valid || out_ready;
    assign in_ready = adv;

    assign nb = {~x2[31], x2[30:0]};
    assign fa = x1;
    assign fb = nb;
    assign a_inf = fa.e == EXP_MAX && fa.m == 23'd0;
    assign a_nan = fa.e == EXP_MAX && fa.m != 23'd0;
    assign b_inf = fb.e == EXP_MAX && fb.m == 23'd0;
    assign b_nan = fb.e == EXP_MAX && fb.m != 23'd0;
    assign swap = {fb.e, fb.m} > {fa.e, fa.m};
    assign xa = swap ? fb : fa;
    assign xb = swap ? fa : fb;
    assign diff = xa.e - xb.e;
    assign sh = diff[4:0];
    assign bb = xb.e != 8'd0 ? {1'b1, xb.m, 3'b000} : 27'd0;

    // bits shifted past the alignment window fold into the LSB as sticky
    always_comb begin
        c1.sp = fa.e == EXP_MAX || fb.e == EXP_MAX;
        c1.spv = (a_nan || b_nan || (a_inf && b_inf && fa.s != fb.s)) ? QNAN : a_inf ? x1 : nb;
        c1.s = xa.s;
        c1.e = xa.e;
        c1.sub = xa.s ^ xb.s;
        c1.a = xa.e != 8'd0 ? {1'b1, xa.m, 3'b000} : 27'd0;
        c1.b = diff >= 8'd26 ? {26'd0, |bb} : (bb >> sh) | {26'd0, |(bb << (5'd27 - sh))};
    end

    always_ff @(posedge clk) begin
        if (rst) v1 <= 1'b0;
        else if (adv) begin
            v1 <= in_valid;
            r1 <= c1;
        end
    end

    assign sum = r1.sub ? {1'b0, r1.a} - {1'b0, r1.b} : {1'b0, r1.a} + {1'b0, r1.b};

    fpu_lzc28 u_lzc (.v(sum), .lz(lz));

    always_comb c2 = '{sp: r1.sp, spv: r1.spv, s: r1.s, e: r1.e, sum: sum, lz: lz};

    always_ff @(posedge clk) begin
        if (rst) v2 <= 1'b0;
        else if (adv) begin
            v2 <= v1;
            r2 <= c2;
        end
    end

    // after the shift t[27] is the hidden bit, so it doubles as the non-zero flag
    assign t = r2.sum << r2.lz;
    assign up = t[3] & (t[2] | t[1] | t[0] | t[4]);
    assign fr = {1'b0, t[26:4]} + {23'd0, up};
    assign en = $signed({2'b00, r2.e}) + 10'sd1 - $signed({5'd0, r2.lz}) + $signed({9'd0, fr[23]});
    assign novf = !r2.sp && t[27] && en >= 10'sd255;
    assign ny = r2.sp ? r2.spv : !t[27] ? 32'h0 : en >= 10'sd255 ? {r2.s, EXP_MAX, 23'd0}
              : en <= 10'sd0 ? {r2.s, 31'd0} : {r2.s, en[7:0], fr[22:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y <= 32'h0;
            ovf <= 1'b0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                y <= ny;
                ovf <= novf;
            end
        end
    end
endmodule
